// File: rtl/risp_run_controller.sv
// Purpose: sequences RUN / CLEAR commands for a spiking network and captures one fire word per timestep.
// Latency: a RUN accepted at cycle T enables the network in T+1..T+N; each word is valid one cycle after its step.
// Backpressure: a pending, unconsumed word stalls net_en; commands are refused until idle with no word pending.
//
// Ports:
//   clk, arstn              - clock, asynchronous active-low reset
//   cmd_valid/ready/op/run  - command handshake: op 00 RUN N timesteps, 01 CLEAR network, others NOP
//   net_en, net_clear       - network timestep enable (combinational) and registered clear pulse
//   net_fire                - output-neuron fire bits, sampled on net_en cycles
//   out_valid/ready/fires/last - one captured timestep per word; last marks the final step of a RUN
//   busy                    - high whenever the controller is not idle
module risp_run_controller #(
  parameter int NUM_OUT   = 1,
  parameter int RUN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [RUN_WIDTH-1:0] cmd_run,
  output logic                 net_en,
  output logic                 net_clear,
  input  logic [NUM_OUT-1:0]   net_fire,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_OUT-1:0]   out_fires,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RUN_WIDTH-1:0]   r_remaining;
  logic [RUN_WIDTH-1:0]   w_remaining_nxt;
  logic                   r_out_valid;
  logic [NUM_OUT-1:0]     r_out_fires;
  logic                   r_out_last;
  logic                   r_net_clear;

  logic                   w_cmd_ready;
  logic                   w_cmd_acc;
  logic                   w_is_run;
  logic                   w_is_clear;
  logic                   w_net_en;
  logic                   w_last_step;

  // Gating with arstn keeps the handshake dead while reset is held, even
  // though the state register already reads IDLE.
  assign w_cmd_ready = arstn && (r_state == ST_IDLE) && !r_out_valid;
  assign w_cmd_acc   = cmd_valid && w_cmd_ready;

  // A zero-length RUN is accepted but behaves exactly like a NOP.
  assign w_is_run    = (cmd_op == OP_RUN) && (cmd_run != '0);
  assign w_is_clear  = (cmd_op == OP_CLEAR);

  // The network only advances when the capture register is free or being
  // drained this cycle, so no fire word is ever overwritten.
  assign w_net_en    = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_last_step = (r_remaining == RUN_WIDTH'(1));

  // Next-state and remaining-count logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc && w_is_run) begin
          w_state_nxt     = ST_RUN;
          w_remaining_nxt = cmd_run;
        end else if (w_cmd_acc && w_is_clear) begin
          w_state_nxt     = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (w_net_en) begin
          w_remaining_nxt = r_remaining - RUN_WIDTH'(1);
          if (w_last_step) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        // Clear lasts exactly the one cycle spent in this state.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // The clear pulse is registered so it coincides with the CLEAR state
  // cycle; net_en cannot be high then because the state is not RUN.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_net_clear <= 1'b0;
    end else begin
      r_net_clear <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Output capture register. A capture takes priority over a consume, so a
  // simultaneous drain-and-refill leaves the new word valid.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_out_valid <= 1'b0;
      r_out_fires <= '0;
      r_out_last  <= 1'b0;
    end else if (w_net_en) begin
      r_out_valid <= 1'b1;
      r_out_fires <= net_fire;
      r_out_last  <= w_last_step;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign net_en    = w_net_en;
  assign net_clear = r_net_clear;
  assign out_valid = r_out_valid;
  assign out_fires = r_out_fires;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/risp_run_controller.md
RISP_RUN_CONTROLLER -- requirements
Module: risp_run_controller

Interface
REQ-001 SHALL have parameter NUM_OUT, default 1: number of network output neurons sampled per timestep.
REQ-002 SHALL have parameter RUN_WIDTH, default 16: width of the run-length field.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port arstn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command present.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 SHALL have port cmd_op, input, 2: 2'b00 RUN, 2'b01 CLEAR, others NOP.
REQ-008 SHALL have port cmd_run, input, RUN_WIDTH: number of timesteps N for RUN; ignored otherwise.
REQ-009 SHALL have port net_en, output, 1: network timestep enable, connected to every neuron en.
REQ-010 SHALL have port net_clear, output, 1: registered one-cycle network clear pulse.
REQ-011 SHALL have port net_fire, input, NUM_OUT: output-neuron fire bits, valid in the same cycle as net_en.
REQ-012 SHALL have port out_valid, output, 1: captured timestep result present.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result when out_valid && out_ready.
REQ-014 SHALL have port out_fires, output, NUM_OUT: captured net_fire for one timestep.
REQ-015 SHALL have port out_last, output, 1: marks the final timestep of a RUN.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL implement the states IDLE, RUN and CLEAR.
REQ-018 SHALL drive cmd_ready = (state==IDLE) && !out_valid, combinationally.
REQ-019 SHALL, on accepting RUN with N>0, load remaining=N and enter RUN on the next cycle.
REQ-020 SHALL, on accepting RUN with N=0 or a NOP, stay in IDLE and produce no net_en and no output word.
REQ-021 SHALL drive net_en = (state==RUN) && (!out_valid || out_ready), combinationally; this stalls the network under backpressure.
REQ-022 SHALL, in every cycle with net_en=1, perform all of the following at the edge:
- register out_fires<=net_fire;
- set out_valid<=1;
- set out_last<=(remaining==1);
- decrement remaining.
REQ-023 SHALL return to IDLE on the edge where net_en=1 and remaining==1.
REQ-024 SHALL clear out_valid on an edge with out_valid && out_ready unless net_en reloads it in the same cycle; a simultaneous consume and capture SHALL leave out_valid=1 with new data.
REQ-025 SHALL hold out_fires and out_last stable while out_valid && !out_ready.
REQ-026 SHALL, on accepting CLEAR, enter CLEAR, assert net_clear for exactly one cycle (the CLEAR state cycle), then return to IDLE.
REQ-027 SHALL never assert net_en and net_clear in the same cycle.
REQ-028 SHALL treat remaining as unsigned RUN_WIDTH; N=2^RUN_WIDTH-1 SHALL produce exactly that many timesteps, with no wrap-around.
REQ-029 SHALL, with continuous out_ready=1 and RUN N accepted at cycle T, assert net_en in cycles T+1..T+N, produce out_valid in T+2..T+N+1, and raise cmd_ready at T+N+2.

Reset
REQ-030 SHALL, on arstn=0 and regardless of clock, force the following values:
- state=IDLE;
- remaining=0;
- out_valid=0, out_fires=0, out_last=0;
- net_clear=0.
REQ-031 SHALL, while in reset, drive net_en=0, busy=0 and cmd_ready=0 (cmd_ready SHALL be gated by arstn).
REQ-032 SHALL, on reset asserted mid-RUN, abandon the run immediately, with no further net_en and no out_last word after release.
REQ-033 SHALL present cmd_ready=1 on the first cycle after arstn deasserts.

Verification
REQ-034 SHALL cover: RUN N=3, out_ready=1, net_fire=1,0,1 on the en cycles -> net_en high for exactly 3 consecutive cycles; words 1,0,1 with out_last=0,0,1; cmd_ready returns 1 cycle after the last word is consumed.
REQ-035 SHALL cover: RUN N=4 with out_ready low for cycles 2-4 after the first word -> net_en low throughout the stall; out_fires held; exactly 4 words total, none lost or duplicated.
REQ-036 SHALL cover: RUN N=0 then NOP (op=2'b11) -> both accepted in consecutive cycles; net_en and out_valid never assert; busy stays 0.
REQ-037 SHALL cover: CLEAR issued while a final word is pending -> cmd_ready=0 until the word is consumed; then net_clear is a single one-cycle pulse and busy=1 for that cycle only.
REQ-038 SHALL cover: arstn pulsed low during the 2nd timestep of RUN N=5 -> out_valid=0, net_en=0 immediately; after release, no further words and cmd_ready=1.
REQ-039 SHALL cover: RUN N=2^RUN_WIDTH-1 with RUN_WIDTH=4 -> exactly 15 net_en cycles, with out_last only on the 15th.
